fpa_sequencer: RTL and testbench

Multi-cycle sequencer for the single-precision floating-point adder datapath (swap, split, barrel-shift alignment, ripple add, normalize). It accepts one operand pair through a valid/ready handshake and steps the datapath through align, add, iterative normalize and pack states. It returns an IEEE-754 binary32 sum on a valid/ready output port. It sits between any requester and the shared adder hardware and replaces the unclocked, loop-based normalization with one bounded shift per cycle.

---
 rtl/fpa_pkg.sv | 33 +++
 rtl/fpa_align.sv | 38 +++
 rtl/fpa_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_fpa_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fpa_pkg.sv
// Shared types and constants for the multi-cycle binary32 adder sequencer.
package fpa_pkg;

    localparam int          EXP_W   = 8;
    localparam int          MAN_W   = 23;
    localparam logic [7:0]  EXP_MAX = 8'hFF;
    localparam logic [31:0] QNAN    = 32'h7FC00000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_ADD   = 3'd2,
        ST_NORM  = 3'd3,
        ST_PACK  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   man;
    } fp_unp_t;

    // Denormals use exponent 1 with a zero hidden bit so alignment needs no special case.
    function automatic fp_unp_t fp_split(input logic [31:0] v);
        fp_unp_t u;
        u.sign = v[31];
        u.exp  = (v[30:23] == 8'd0) ? 8'd1 : v[30:23];
        u.man  = {|v[30:23], v[22:0]};
        return u;
    endfunction

endpackage

// File: rtl/fpa_align.sv
// Combinational swap, split and right-shift alignment; the smaller operand is
// returned as a 27-bit mantissa {man24, guard, round, sticky}.
module fpa_align
    import fpa_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output fp_unp_t     o_big,
    output logic        o_small_sign,
    output logic [26:0] o_small_man
);

    logic        w_swap;
    fp_unp_t     w_small;
    logic [7:0]  w_ediff;
    logic [26:0] w_ext;
    logic [26:0] w_shifted;
    logic [26:0] w_lost;

    assign w_swap       = i_b[30:0] > i_a[30:0];
    assign o_big        = fp_split(w_swap ? i_b : i_a);
    assign w_small      = fp_split(w_swap ? i_a : i_b);
    assign o_small_sign = w_small.sign;
    assign w_ediff      = o_big.exp - w_small.exp;
    assign w_ext        = {w_small.man, 3'b000};

    // Beyond 27 positions every bit of the small mantissa collapses into sticky.
    always_comb begin
        w_shifted = '0;
        w_lost    = w_ext;
        if (w_ediff < 8'd27) begin
            w_shifted = w_ext >> w_ediff;
            w_lost    = w_ext & ~(27'h7FFFFFF << w_ediff);
        end
        o_small_man = {w_shifted[26:1], w_shifted[0] | (|w_lost)};
    end

endmodule

// File: rtl/fpa_sequencer.sv
// Multi-cycle binary32 adder: IDLE, ALIGN, ADD, NORM (one shift per cycle), PACK, DONE.
// Define FPA_SEQ_RNE_EN for round-to-nearest-even; the default build truncates.
module fpa_sequencer
    import fpa_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy,
    output state_t      o_state
);

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_op_a;
    logic [31:0] r_op_b;
    logic        r_sign;
    logic        r_sub;
    logic [9:0]  r_exp;
    logic [23:0] r_ma;
    logic [26:0] r_mb;
    logic [27:0] r_sum;
    logic        r_special;
    logic [31:0] r_spec_val;
    logic [31:0] r_result;

    fp_unp_t     w_big;
    logic        w_small_sign;
    logic [26:0] w_small_man;

    logic        w_accept;
    logic        w_a_max;
    logic        w_b_max;
    logic        w_a_nan;
    logic        w_b_nan;
    logic        w_inf_clash;
    logic        w_special;
    logic [31:0] w_spec_val;

    logic [26:0] w_mb_eff;
    logic [27:0] w_add_a;
    logic [27:0] w_add_b;
    logic [27:0] w_sum;
    logic        w_sum_zero;
    logic        w_norm_left;

    logic        w_round_up;
    logic [24:0] w_man_rnd;
    logic [9:0]  w_exp_fin;
    logic        w_hid_fin;
    logic [22:0] w_frac_fin;
    logic [31:0] w_packed;

    fpa_align u_align (
        .i_a          (r_op_a),
        .i_b          (r_op_b),
        .o_big        (w_big),
        .o_small_sign (w_small_sign),
        .o_small_man  (w_small_man)
    );

    assign w_accept = in_valid && in_ready;

    // Specials: NaN or opposing infinities give QNAN, otherwise the larger operand is the infinity.
    assign w_a_max     = r_op_a[30:23] == EXP_MAX;
    assign w_b_max     = r_op_b[30:23] == EXP_MAX;
    assign w_a_nan     = w_a_max && (r_op_a[22:0] != 23'd0);
    assign w_b_nan     = w_b_max && (r_op_b[22:0] != 23'd0);
    assign w_inf_clash = w_a_max && w_b_max && !w_a_nan && !w_b_nan && (r_op_a[31] ^ r_op_b[31]);
    assign w_special   = w_a_max || w_b_max;
    assign w_spec_val  = (w_a_nan || w_b_nan || w_inf_clash) ? QNAN : {w_big.sign, EXP_MAX, 23'd0};

`ifdef FPA_SEQ_RNE_EN
    assign w_mb_eff = r_mb;
`else
    assign w_mb_eff = r_mb & 27'h7FFFFF8;
`endif

    // Sum layout: [27] carry, [26:3] mantissa, [2:0] guard/round/sticky.
    assign w_add_a     = {1'b0, r_ma, 3'b000};
    assign w_add_b     = {1'b0, w_mb_eff};
    assign w_sum       = r_sub ? (w_add_a - w_add_b) : (w_add_a + w_add_b);
    assign w_sum_zero  = r_sum == 28'd0;
    assign w_norm_left = !r_special && !r_sum[27] && !w_sum_zero && !r_sum[26] && (r_exp != 10'd1);

`ifdef FPA_SEQ_RNE_EN
    assign w_round_up = r_sum[2] & (r_sum[1] | r_sum[0] | r_sum[3]);
`else
    assign w_round_up = 1'b0;
`endif

    assign w_man_rnd  = {1'b0, r_sum[26:3]} + {24'd0, w_round_up};
    assign w_exp_fin  = w_man_rnd[24] ? (r_exp + 10'd1) : r_exp;
    assign w_hid_fin  = w_man_rnd[24] | w_man_rnd[23];
    assign w_frac_fin = w_man_rnd[24] ? 23'd0 : w_man_rnd[22:0];

    always_comb begin
        w_packed = {r_sign, w_exp_fin[7:0] & {8{w_hid_fin}}, w_frac_fin};
        if (r_special) begin
            w_packed = r_spec_val;
        end else if (w_sum_zero) begin
            w_packed = 32'd0;
        end else if (w_exp_fin >= 10'd255) begin
            w_packed = {r_sign, EXP_MAX, 23'd0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next = ST_ALIGN;
            ST_ALIGN: w_next = ST_ADD;
            ST_ADD:   w_next = ST_NORM;
            ST_NORM:  if (!w_norm_left) w_next = ST_PACK;
            ST_PACK:  w_next = ST_DONE;
            ST_DONE:  if (out_ready) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op_a <= in_a;
                        r_op_b <= in_b;
                    end
                end
                ST_ALIGN: begin
                    r_sign     <= w_big.sign;
                    r_sub      <= w_big.sign ^ w_small_sign;
                    r_exp      <= {2'b00, w_big.exp};
                    r_ma       <= w_big.man;
                    r_mb       <= w_small_man;
                    r_special  <= w_special;
                    r_spec_val <= w_spec_val;
                end
                ST_ADD: r_sum <= w_sum;
                ST_NORM: begin
                    if (!r_special) begin
                        if (r_sum[27]) begin
                            r_sum <= {1'b0, r_sum[27:2], r_sum[1] | r_sum[0]};
                            r_exp <= r_exp + 10'd1;
                        end else if (w_norm_left) begin
                            r_sum <= {r_sum[26:0], 1'b0};
                            r_exp <= r_exp - 10'd1;
                        end
                    end
                end
                ST_PACK: r_result <= w_packed;
                default: ;
            endcase
        end
    end

    assign result  = r_result;
    assign o_state = r_state;

endmodule

// File: tb/tb_fpa_sequencer.sv
// Self-checking bench for fpa_sequencer: vector table, random exact sums,
// output back-pressure and mid-operation reset.
module tb_fpa_sequencer;
  import fpa_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;
  state_t      dbg_state;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t        vecs[15];
  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          total = 0;
  int          bad   = 0;

  fpa_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy),
    .o_state   (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", name, act, req);
    end
  endtask

  // Called on a negedge; returns on the negedge that starts cycle 1.
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input int lat, input bit push);
    check("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    if (push) begin
      exp_q.push_back(res);
      lat_q.push_back(lat);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collect(input int hold);
    int          cyc;
    logic [31:0] want;
    int          want_lat;
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      check("busy_in_flight", {31'd0, busy}, 32'd1);
      @(negedge clk);
      cyc++;
    end
    want     = exp_q.pop_front();
    want_lat = lat_q.pop_front();
    check("latency", cyc, want_lat);
    check("result", result, want);
    for (int i = 0; i < hold; i++) begin
      if (i == 3) begin
        in_a     = 32'h3F800000;
        in_b     = 32'h3F800000;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      check("hold_result_stable", result, want);
      check("hold_in_ready_low", {31'd0, in_ready}, 32'd0);
      check("hold_out_valid_high", {31'd0, out_valid}, 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready_after_take", {31'd0, in_ready}, 32'd1);
    check("out_valid_after_take", {31'd0, out_valid}, 32'd0);
    if (cyc >= 200) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  initial begin
    int          e;
    int          m;
    int          cyc;
    logic [31:0] x;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = 32'd0;
    in_b      = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    rst = 1'b0;
    @(negedge clk);

    vecs[0]  = '{32'h40A00000, 32'h40400000, 32'h41000000, 5};
    vecs[1]  = '{32'h3F800000, 32'hBF800000, 32'h00000000, 5};
    vecs[2]  = '{32'h3F800000, 32'hBF7FFFFE, 32'h34000000, 28};
    vecs[3]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 5};
    vecs[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 5};
    vecs[5]  = '{32'h3F800000, 32'h3F800000, 32'h40000000, 5};
    vecs[6]  = '{32'h3F800000, 32'h40000000, 32'h40400000, 5};
    vecs[7]  = '{32'h40400000, 32'hBF800000, 32'h40000000, 5};
    vecs[8]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 5};
    vecs[9]  = '{32'h7F800000, 32'h3F800000, 32'h7F800000, 5};
    vecs[10] = '{32'hFF800000, 32'h40A00000, 32'hFF800000, 5};
    vecs[11] = '{32'h00000001, 32'h00000001, 32'h00000002, 5};
    vecs[12] = '{32'h00400000, 32'h00400000, 32'h00800000, 5};
    vecs[13] = '{32'hBF800000, 32'h3F000000, 32'hBF000000, 6};
    vecs[14] = '{32'h3F800000, 32'h30800000, 32'h3F800000, 5};

    for (int i = 0; i < 15; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, 1'b1);
      collect(0);
    end

    // 2^k + 2^k doubles exactly; x + (-x) is always +0.
    for (int i = 0; i < 6; i++) begin
      e = $urandom_range(1, 253);
      x = {1'b0, 8'(e), 23'd0};
      send(x, x, {1'b0, 8'(e + 1), 23'd0}, 5, 1'b1);
      collect(0);
      e = $urandom_range(1, 254);
      m = $urandom_range(0, 32'h7FFFFF);
      x = {1'b0, 8'(e), 23'(m)};
      send(x, {1'b1, x[30:0]}, 32'd0, 5, 1'b1);
      collect(0);
    end

    send(32'h40A00000, 32'h40400000, 32'h41000000, 5, 1'b1);
    collect(10);
    repeat (2) @(negedge clk);
    check("ignored_pulse_no_busy", {31'd0, busy}, 32'd0);

    // Reset lands in cycle 10 of the long normalisation.
    send(32'h3F800000, 32'hBF7FFFFE, 32'd0, 0, 1'b0);
    cyc = 1;
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("busy_before_abort", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});

    send(32'h40A00000, 32'h40400000, 32'h41000000, 5, 1'b1);
    collect(0);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
